// File: rtl/shift_sin_pout_rx.sv
// Serial-in / parallel-out receiver: synchronises an external sclk/select/sin
// interface and delivers 9-bit frames (8 data MSB-first + even parity) to a consumer.
module shift_sin_pout_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       sclk,
    input  logic       select,
    input  logic       sin,
    output logic [7:0] data_out,
    output logic       parity_err,
    output logic       data_valid,
    input  logic       data_ack,
    output logic       overrun,
    output logic       abort,
    output logic       busy
);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] sel_sync;
    logic [SYNC_STAGES-1:0] sin_sync;
    logic                   sclk_hist;
    logic [7:0]             shreg;
    logic [3:0]             bit_cnt;

    logic sclk_s;
    logic sel_s;
    logic sin_s;
    logic shift_evt;
    logic frame_done;
    logic ack_ok;

    // History flop resets high so an sclk held high through reset is not an edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_sync <= '0;
            sel_sync  <= '0;
            sin_sync  <= '0;
            sclk_hist <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            sel_sync  <= {sel_sync[SYNC_STAGES-2:0], select};
            sin_sync  <= {sin_sync[SYNC_STAGES-2:0], sin};
            sclk_hist <= sclk_s;
        end
    end

    assign sclk_s     = sclk_sync[SYNC_STAGES-1];
    assign sel_s      = sel_sync[SYNC_STAGES-1];
    assign sin_s      = sin_sync[SYNC_STAGES-1];
    assign shift_evt  = (state == SHIFT) && sel_s && sclk_s && !sclk_hist;
    assign frame_done = shift_evt && (bit_cnt == 4'd8);
    assign ack_ok     = data_valid && data_ack;

    // A select fall wins over a coincident shift event.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            abort   <= 1'b0;
            shreg   <= 8'h00;
            bit_cnt <= 4'd0;
        end else begin
            abort <= 1'b0;
            case (state)
                IDLE: begin
                    if (sel_s) begin
                        state <= SHIFT;
                        busy  <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (!sel_s) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        abort   <= (bit_cnt != 4'd0);
                        shreg   <= 8'h00;
                        bit_cnt <= 4'd0;
                    end else if (shift_evt) begin
                        if (bit_cnt == 4'd8) begin
                            shreg   <= 8'h00;
                            bit_cnt <= 4'd0;
                        end else begin
                            shreg   <= {shreg[6:0], sin_s};
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Output holding register; an ack in the completion cycle frees the slot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out   <= 8'h00;
            parity_err <= 1'b0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
        end else if (frame_done) begin
            if (!data_valid || data_ack) begin
                data_out   <= shreg;
                parity_err <= ^{shreg, sin_s};
                data_valid <= 1'b1;
                if (ack_ok)
                    overrun <= 1'b0;
            end else begin
                overrun <= 1'b1;
            end
        end else if (ack_ok) begin
            data_valid <= 1'b0;
            overrun    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_shift_sin_pout_rx.sv
// Bench for shift_sin_pout_rx: table of known frames, hand sequences for the
// timing corners, then random frames/aborts/acks against a frame-level model.
module tb_shift_sin_pout_rx;

    localparam int SYNC = 2;

    logic       clk;
    logic       reset_n;
    logic       sclk;
    logic       select;
    logic       sin;
    logic [7:0] data_out;
    logic       parity_err;
    logic       data_valid;
    logic       data_ack;
    logic       overrun;
    logic       abort;
    logic       busy;

    int vectors;
    int miscompares;
    int abort_seen;

    // Frame-level reference state
    logic [7:0] m_data;
    logic       m_perr;
    logic       m_valid;
    logic       m_ovr;
    int         m_aborts;
    logic       bitq[$];

    typedef struct {
        logic [7:0] data;
        logic       pbit;
        logic       ack;
        logic [7:0] exp_data;
        logic       exp_perr;
        logic       exp_valid;
        logic       exp_ovr;
    } vec_t;

    vec_t vecs[6];

    shift_sin_pout_rx #(.SYNC_STAGES(SYNC)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .sclk(sclk),
        .select(select),
        .sin(sin),
        .data_out(data_out),
        .parity_err(parity_err),
        .data_valid(data_valid),
        .data_ack(data_ack),
        .overrun(overrun),
        .abort(abort),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (abort === 1'b1)
            abort_seen++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        bitq.delete();
        m_data  = 8'h00;
        m_perr  = 1'b0;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
    endtask

    task automatic model_bit(input logic b);
        int d;
        int ones;
        bitq.push_back(b);
        if (bitq.size() == 9) begin
            d    = 0;
            ones = 0;
            for (int i = 0; i < 8; i++)
                d = d * 2 + int'(bitq[i]);
            for (int i = 0; i < 9; i++)
                ones += int'(bitq[i]);
            if (!m_valid) begin
                m_data  = 8'(d);
                m_perr  = 1'(ones % 2);
                m_valid = 1'b1;
            end else begin
                m_ovr = 1'b1;
            end
            bitq.delete();
        end
    endtask

    task automatic model_ack();
        if (m_valid) begin
            m_valid = 1'b0;
            m_ovr   = 1'b0;
        end
    endtask

    task automatic send_bit(input logic b);
        sin  = b;
        sclk = 1'b0;
        tick(4);
        sclk = 1'b1;
        tick(4);
        model_bit(b);
    endtask

    task automatic applyStimulus(input logic [7:0] d, input logic p);
        for (int i = 7; i >= 0; i--)
            send_bit(d[i]);
        send_bit(p);
    endtask

    task automatic do_ack();
        data_ack = 1'b1;
        tick(1);
        data_ack = 1'b0;
        tick(2);
        model_ack();
    endtask

    task automatic drop_select();
        select = 1'b0;
        tick(6);
        if (bitq.size() > 0)
            m_aborts++;
        bitq.delete();
    endtask

    task automatic raise_select();
        select = 1'b1;
        tick(4);
    endtask

    task automatic checkOutput(input string tag);
        cmp({tag, "_data"}, 32'(data_out), 32'(m_data));
        cmp({tag, "_perr"}, 32'(parity_err), 32'(m_perr));
        cmp({tag, "_valid"}, 32'(data_valid), 32'(m_valid));
        cmp({tag, "_ovr"}, 32'(overrun), 32'(m_ovr));
        cmp({tag, "_aborts"}, 32'(abort_seen), 32'(m_aborts));
    endtask

    initial begin
        logic [7:0] d;
        logic       p;
        int         k;
        vectors     = 0;
        miscompares = 0;
        abort_seen  = 0;
        m_aborts    = 0;
        model_reset();

        vecs[0] = '{8'h3C, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{8'h01, 1'b1, 1'b0, 8'h01, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{8'h80, 1'b1, 1'b1, 8'h01, 1'b0, 1'b1, 1'b1};
        vecs[3] = '{8'h96, 1'b0, 1'b1, 8'h96, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{8'hE7, 1'b0, 1'b1, 8'hE7, 1'b0, 1'b1, 1'b0};

        reset_n  = 1'b0;
        sclk     = 1'b1;
        select   = 1'b0;
        sin      = 1'b0;
        data_ack = 1'b0;
        tick(3);
        cmp("rst_data", 32'(data_out), 32'h00);
        cmp("rst_valid", 32'(data_valid), 32'h0);
        cmp("rst_busy", 32'(busy), 32'h0);
        cmp("rst_abort", 32'(abort), 32'h0);
        reset_n = 1'b1;
        tick(3);
        cmp("idle_busy", 32'(busy), 32'h0);
        raise_select();
        cmp("sel_busy", 32'(busy), 32'h1);

        // Frame 0xA5 with exact delivery latency on the ninth sclk rise
        d = 8'hA5;
        for (int i = 7; i >= 0; i--)
            send_bit(d[i]);
        sin  = 1'b0;
        sclk = 1'b0;
        tick(4);
        sclk = 1'b1;
        tick(SYNC);
        cmp("lat_early_valid", 32'(data_valid), 32'h0);
        tick(1);
        cmp("lat_valid", 32'(data_valid), 32'h1);
        cmp("lat_data", 32'(data_out), 32'hA5);
        cmp("lat_perr", 32'(parity_err), 32'h0);
        tick(3);
        model_bit(1'b0);
        do_ack();
        checkOutput("a5_acked");

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].data, vecs[i].pbit);
            cmp($sformatf("tbl%0d_data", i), 32'(data_out), 32'(vecs[i].exp_data));
            cmp($sformatf("tbl%0d_perr", i), 32'(parity_err), 32'(vecs[i].exp_perr));
            cmp($sformatf("tbl%0d_valid", i), 32'(data_valid), 32'(vecs[i].exp_valid));
            cmp($sformatf("tbl%0d_ovr", i), 32'(overrun), 32'(vecs[i].exp_ovr));
            if (vecs[i].ack) begin
                do_ack();
                cmp($sformatf("tbl%0d_ack_valid", i), 32'(data_valid), 32'h0);
                cmp($sformatf("tbl%0d_ack_ovr", i), 32'(overrun), 32'h0);
            end
        end

        // Abort after 4 bits while a frame is pending
        applyStimulus(8'h81, 1'b0);
        d = 8'hC3;
        for (int i = 7; i >= 4; i--)
            send_bit(d[i]);
        drop_select();
        cmp("abort_count", 32'(abort_seen), 32'(m_aborts));
        cmp("abort_valid", 32'(data_valid), 32'h1);
        cmp("abort_data", 32'(data_out), 32'h81);
        cmp("abort_busy", 32'(busy), 32'h0);
        raise_select();
        do_ack();
        applyStimulus(8'hFF, 1'b0);
        cmp("ff_data", 32'(data_out), 32'hFF);
        cmp("ff_perr", 32'(parity_err), 32'h0);
        drop_select();
        cmp("noabort_count", 32'(abort_seen), 32'(m_aborts));
        raise_select();
        do_ack();

        // Ack in the same cycle as completion of 0x55 with 0x12 pending
        applyStimulus(8'h12, 1'b0);
        checkOutput("pend12");
        d = 8'h55;
        for (int i = 7; i >= 0; i--)
            send_bit(d[i]);
        sin  = 1'b0;
        sclk = 1'b0;
        tick(4);
        sclk = 1'b1;
        tick(SYNC);
        data_ack = 1'b1;
        tick(1);
        data_ack = 1'b0;
        cmp("simul_valid", 32'(data_valid), 32'h1);
        cmp("simul_data", 32'(data_out), 32'h55);
        cmp("simul_ovr", 32'(overrun), 32'h0);
        tick(3);
        model_ack();
        model_bit(1'b0);
        checkOutput("simul");

        // Reset mid-frame with sclk high and a frame pending
        for (int i = 0; i < 5; i++)
            send_bit(1'b1);
        reset_n = 1'b0;
        tick(1);
        cmp("mrst_data", 32'(data_out), 32'h00);
        cmp("mrst_perr", 32'(parity_err), 32'h0);
        cmp("mrst_valid", 32'(data_valid), 32'h0);
        cmp("mrst_ovr", 32'(overrun), 32'h0);
        cmp("mrst_abort", 32'(abort), 32'h0);
        cmp("mrst_busy", 32'(busy), 32'h0);
        tick(2);
        reset_n = 1'b1;
        model_reset();
        tick(6);
        cmp("mrst_aborts", 32'(abort_seen), 32'(m_aborts));
        cmp("mrst_busy_after", 32'(busy), 32'h1);
        applyStimulus(8'h0F, 1'b0);
        cmp("post_rst_data", 32'(data_out), 32'h0F);
        checkOutput("post_rst");

        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 9) < 2) begin
                k = $urandom_range(0, 8);
                for (int i = 0; i < k; i++)
                    send_bit(1'($urandom_range(0, 1)));
                drop_select();
                raise_select();
            end else begin
                d = 8'($urandom);
                p = (^d) ^ ($urandom_range(0, 3) == 0);
                applyStimulus(d, p);
            end
            if ($urandom_range(0, 2) == 0)
                do_ack();
            checkOutput($sformatf("rnd%0d", it));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/shift_sin_pout_rx.md
SHIFT_SIN_POUT_RX -- requirements
Module: shift_sin_pout_rx

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, the number of synchroniser flops per asynchronous input (legal 2..4).
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port sclk  input  1  external shift clock, asynchronous to clk.
REQ-005 SHALL have port select  input  1  external frame select, asynchronous, active-high.
REQ-006 SHALL have port sin  input  1  external serial data, asynchronous.
REQ-007 SHALL have port data_out  output  8  last accepted byte.
REQ-008 SHALL have port parity_err  output  1  parity status of the byte on data_out.
REQ-009 SHALL have port data_valid  output  1  data_out/parity_err hold an unconsumed frame.
REQ-010 SHALL have port data_ack  input  1  consumer acknowledge.
REQ-011 SHALL have port overrun  output  1  sticky: a completed frame was dropped.
REQ-012 SHALL have port abort  output  1  one-cycle pulse: partial frame discarded.
REQ-013 SHALL have port busy  output  1  high while in SHIFT state.

Function
REQ-014 SHALL pass sclk, select, sin each through SYNC_STAGES flops; only synchronised copies drive logic.
REQ-015 SHALL define a shift event as synchronised sclk 0->1 (one extra history flop) while in SHIFT and synchronised select = 1.
REQ-016 SHALL use FSM states IDLE and SHIFT; IDLE->SHIFT when synchronised select = 1; SHIFT->IDLE when synchronised select = 0.
REQ-017 SHALL, on each shift event, shift the synchronised sin into an 8-bit register LSB-side (MSB-first) and increment a 4-bit bit counter.
REQ-018 SHALL treat each frame as 9 bits: data[7] first, data[0] eighth, parity ninth; the parity bit equals XOR of the 8 data bits (even parity over all 9 bits).
REQ-019 SHALL, on the ninth shift event, set the counter to 0, stay in SHIFT, and deliver: data_out = the 8 shifted data bits, parity_err = XOR of all 9 bits.
REQ-020 SHALL accept back-to-back frames while select stays high; no gap cycles are required.
REQ-021 SHALL assert data_valid on the clk edge that delivers the frame, i.e. SYNC_STAGES+1 clk edges after the first edge that samples the ninth sclk high.
REQ-022 SHALL hold data_valid, data_out and parity_err stable until a cycle with data_valid = 1 and data_ack = 1; data_valid clears on the following edge.
REQ-023 SHALL ignore data_ack while data_valid = 0.
REQ-024 SHALL, if a frame completes while data_valid = 1 and data_ack = 0, drop the new frame, keep the old outputs, and set overrun = 1.
REQ-025 SHALL, if a frame completes in the same cycle as an accepted data_ack, load the new frame, keep data_valid = 1, and not set overrun.
REQ-026 SHALL clear overrun only on an accepted data_ack.
REQ-027 SHALL, on SHIFT->IDLE with bit counter 1..8, pulse abort for one cycle, discard the partial bits and zero the counter; with counter 0 no abort.
REQ-028 SHALL, when a shift event and a select fall are seen in the same cycle, give the select fall priority (no shift, abort per REQ-027).
REQ-029 SHALL require of the environment sclk high/low times and sin setup/hold around sclk rise of at least SYNC_STAGES+1 clk periods; behaviour outside this is undefined.

Reset
REQ-030 SHALL, while reset_n = 0, force state IDLE, counter 0, shift register 0, data_out 0x00, parity_err 0, data_valid 0, overrun 0, abort 0, busy 0, sclk/select/sin synchronisers 0, and the sclk history flop 1, so an sclk held high through reset is not an edge.
REQ-031 SHALL discard any partial frame and any pending data_valid on reset mid-operation without pulsing abort.

Verification
REQ-032 SHALL cover: select=1, frame 0xA5 + parity 0 -> data_out=0xA5, parity_err=0, data_valid=1 at REQ-021 latency.
REQ-033 SHALL cover: frame 0x3C with parity bit 1 -> data_out=0x3C, parity_err=1.
REQ-034 SHALL cover: frames 0x01 then 0x80 (parity 1 each), no ack between -> data_out=0x01, overrun=1; ack -> data_valid=0, overrun=0.
REQ-035 SHALL cover: select dropped after 4 bits -> one-cycle abort, data_valid unchanged; next full frame 0xFF, parity 0 -> data_out=0xFF.
REQ-036 SHALL cover: ack held in the cycle frame 0x55 (parity 0) completes with 0x12 pending -> data_out=0x55, data_valid stays 1, overrun=0.
REQ-037 SHALL cover: reset_n pulsed low after 5 bits with sclk high -> all outputs 0, no abort; new 9-bit frame 0x0F, parity 0 decoded correctly.
